// File: rtl/sfx_pkg.sv
// Shared codes, FSM encoding and note tables for the sound-effect sequencer.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package sfx_pkg;

  localparam logic [1:0] SFX_NONE  = 2'd0;
  localparam logic [1:0] SFX_JUMP  = 2'd1;
  localparam logic [1:0] SFX_SCORE = 2'd2;
  localparam logic [1:0] SFX_DIE   = 2'd3;

  localparam int ROM_DIV_W = 22;
  localparam int DUR_W     = 3;
  localparam int IDX_W     = 3;

  // Effect lengths in notes
  localparam int JUMP_LEN  = 2;
  localparam int SCORE_LEN = 4;
  localparam int DIE_LEN   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_DONE = 2'd3
  } sfx_state_t;

  typedef struct packed {
    logic [ROM_DIV_W-1:0] div;
    logic [DUR_W-1:0]     dur;
  } note_entry_t;

  // Note tables: div is the half-period divider (0 = rest), dur in beat ticks
  function automatic note_entry_t rom_entry(input logic [1:0] id, input logic [IDX_W-1:0] idx);
    note_entry_t e;
    e = '{div: '0, dur: 3'd1};
    case ({id, idx})
      {SFX_JUMP,  3'd0}: e = '{div: 22'd47755,  dur: 3'd2};
      {SFX_JUMP,  3'd1}: e = '{div: 22'd37907,  dur: 3'd2};
      {SFX_SCORE, 3'd0}: e = '{div: 22'd37907,  dur: 3'd1};
      {SFX_SCORE, 3'd1}: e = '{div: 22'd31887,  dur: 3'd1};
      {SFX_SCORE, 3'd2}: e = '{div: 22'd23889,  dur: 3'd2};
      {SFX_SCORE, 3'd3}: e = '{div: 22'd0,      dur: 3'd1};
      {SFX_DIE,   3'd0}: e = '{div: 22'd127551, dur: 3'd2};
      {SFX_DIE,   3'd1}: e = '{div: 22'd151515, dur: 3'd2};
      {SFX_DIE,   3'd2}: e = '{div: 22'd190839, dur: 3'd2};
      {SFX_DIE,   3'd3}: e = '{div: 22'd0,      dur: 3'd1};
      {SFX_DIE,   3'd4}: e = '{div: 22'd381679, dur: 3'd4};
      default:           e = '{div: '0, dur: 3'd1};
    endcase
    return e;
  endfunction

  // Index of the final note of each effect
  function automatic logic [IDX_W-1:0] sfx_last_idx(input logic [1:0] id);
    case (id)
      SFX_JUMP:  return IDX_W'(JUMP_LEN - 1);
      SFX_SCORE: return IDX_W'(SCORE_LEN - 1);
      SFX_DIE:   return IDX_W'(DIE_LEN - 1);
      default:   return '0;
    endcase
  endfunction

endpackage

// File: rtl/sfx_rom.sv
// Combinational note lookup: (effect, note index) -> divider, duration, last-note flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the sequencer holds all timing state.
module sfx_rom
  import sfx_pkg::*;
(
  input  logic [1:0]           sfx_id,
  input  logic [IDX_W-1:0]     idx,
  output logic [ROM_DIV_W-1:0] div,
  output logic [DUR_W-1:0]     dur,
  output logic                 last
);

  note_entry_t ent;

  // Table lookup plus end-of-effect detection
  always_comb begin
    ent  = rom_entry(sfx_id, idx);
    div  = ent.div;
    dur  = ent.dur;
    last = (idx == sfx_last_idx(sfx_id));
  end

endmodule

// File: rtl/sfx_sequencer.sv
// Turns game event pulses into timed note sequences for the note generator (optional SFX_QUEUE_EN adds a one-deep pending effect).
// Latency: event sampled at edge n, LOAD in cycle n+1, first note on note_div/note_valid from cycle n+2.
// Backpressure: none; events are pulses that preempt (priority >= current) or are dropped (or held pending).
module sfx_sequencer
  import sfx_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 24,
  parameter int DIV_W   = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evt_jump,
  input  logic             evt_score,
  input  logic             evt_die,
  input  logic             mute,
  output logic [DIV_W-1:0] note_div,
  output logic             note_valid,
  output logic             busy,
  output logic [1:0]       sfx_id,
  output logic             sfx_done
);

  localparam int TICK_CYC = CLK_HZ / TICK_HZ;
  localparam int TICK_W   = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);

  sfx_state_t           state;
  logic [IDX_W-1:0]     idx;
  logic [TICK_W-1:0]    tick_cnt;
  logic [DUR_W-1:0]     dur_cnt;
  logic [1:0]           evt_code;
  logic                 accept;
  logic [ROM_DIV_W-1:0] rom_div;
  logic [DUR_W-1:0]     rom_dur;
  logic                 rom_last;
`ifdef SFX_QUEUE_EN
  logic [1:0]           pend_id;
`endif

  // Priority encode the event pulses; sfx_id is 0 only in IDLE, so the >= test also covers idle acceptance
  always_comb begin
    evt_code = SFX_NONE;
    if (evt_die)        evt_code = SFX_DIE;
    else if (evt_score) evt_code = SFX_SCORE;
    else if (evt_jump)  evt_code = SFX_JUMP;
    accept = (evt_code != SFX_NONE) && (evt_code >= sfx_id);
  end

  sfx_rom u_rom (
    .sfx_id (sfx_id),
    .idx    (idx),
    .div    (rom_div),
    .dur    (rom_dur),
    .last   (rom_last)
  );

  // Sequencer FSM with registered outputs; note_valid is left untouched when entering LOAD so it holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      tick_cnt   <= '0;
      dur_cnt    <= '0;
      note_div   <= '0;
      note_valid <= 1'b0;
      busy       <= 1'b0;
      sfx_id     <= SFX_NONE;
      sfx_done   <= 1'b0;
`ifdef SFX_QUEUE_EN
      pend_id    <= SFX_NONE;
`endif
    end else begin
      sfx_done <= 1'b0;
      if (accept) begin
        state    <= ST_LOAD;
        sfx_id   <= evt_code;
        idx      <= '0;
        tick_cnt <= '0;
        dur_cnt  <= '0;
        busy     <= 1'b1;
`ifdef SFX_QUEUE_EN
        if (pend_id <= evt_code) pend_id <= SFX_NONE;
`endif
      end else begin
`ifdef SFX_QUEUE_EN
        // A dropped lower-priority event waits here; only a higher one replaces it
        if ((evt_code != SFX_NONE) && (evt_code > pend_id)) pend_id <= evt_code;
`endif
        case (state)
          ST_IDLE: begin
            busy <= 1'b0;
          end
          ST_LOAD: begin
            note_div   <= DIV_W'(rom_div);
            dur_cnt    <= rom_dur;
            tick_cnt   <= '0;
            note_valid <= (rom_div != '0) && !mute;
            state      <= ST_PLAY;
          end
          ST_PLAY: begin
            note_valid <= (note_div != '0) && !mute;
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              dur_cnt  <= dur_cnt - DUR_W'(1);
              if (dur_cnt == DUR_W'(1)) begin
                if (rom_last) begin
                  state      <= ST_DONE;
                  note_valid <= 1'b0;
                  sfx_done   <= 1'b1;
                end else begin
                  idx        <= idx + IDX_W'(1);
                  state      <= ST_LOAD;
                  note_valid <= note_valid;
                end
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
          ST_DONE: begin
`ifdef SFX_QUEUE_EN
            if (pend_id != SFX_NONE) begin
              state   <= ST_LOAD;
              sfx_id  <= pend_id;
              idx     <= '0;
              pend_id <= SFX_NONE;
            end else begin
              state  <= ST_IDLE;
              sfx_id <= SFX_NONE;
              busy   <= 1'b0;
            end
`else
            state  <= ST_IDLE;
            sfx_id <= SFX_NONE;
            busy   <= 1'b0;
`endif
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
